// File: rtl/cpu_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_boot_sequencer
// Brief    : Drives a single-cycle CPU through pre-load reset, program load from
//            a valid/ready instruction stream, post-load reset and a run window.
//            Optional LOAD idle watchdog enabled by defining SEQ_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_boot_sequencer #(
    parameter int IMEM_DEPTH  = 64,
    parameter int CNT_W       = 7,
    parameter int WDOG_CYCLES = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [15:0]      run_cycles,
    input  logic             halt_req,
    input  logic             instr_valid,
    input  logic [31:0]      instr_data,
    input  logic             instr_last,
    output logic             instr_ready,
    output logic             cpu_reset,
    output logic             cpu_load,
    output logic [31:0]      cpu_instr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] load_count,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRE_RST  = 3'd1,
        S_LOAD     = 3'd2,
        S_POST_RST = 3'd3,
        S_RUN      = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_load_end, w_load_end_nxt;
    logic [15:0]      r_run_len, w_run_len_nxt;
    logic [15:0]      r_run_cnt, w_run_cnt_nxt;
    logic             r_instr_ready, w_instr_ready_nxt;
    logic             r_cpu_reset, w_cpu_reset_nxt;
    logic             r_cpu_load, w_cpu_load_nxt;
    logic [31:0]      r_cpu_instr, w_cpu_instr_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [CNT_W-1:0] r_load_count, w_load_count_nxt;
    logic             r_err, w_err_nxt;

    logic w_beat;
    logic w_last_slot;

`ifdef SEQ_WATCHDOG_EN
    localparam int c_wdog_w = $clog2(WDOG_CYCLES + 1);
    logic [c_wdog_w-1:0] r_wdog_cnt, w_wdog_cnt_nxt;
`endif

    assign w_beat      = r_instr_ready & instr_valid;
    assign w_last_slot = (r_load_count == CNT_W'(IMEM_DEPTH - 1));

    // r_load_end marks the cycle carrying the final load pulse, so the
    // post-load reset never overlaps an instruction write.
    always_comb begin
        w_state_nxt       = r_state;
        w_load_end_nxt    = r_load_end;
        w_run_len_nxt     = r_run_len;
        w_run_cnt_nxt     = r_run_cnt;
        w_instr_ready_nxt = r_instr_ready;
        w_cpu_reset_nxt   = r_cpu_reset;
        w_cpu_load_nxt    = 1'b0;
        w_cpu_instr_nxt   = r_cpu_instr;
        w_busy_nxt        = r_busy;
        w_done_nxt        = r_done;
        w_load_count_nxt  = r_load_count;
        w_err_nxt         = r_err;
`ifdef SEQ_WATCHDOG_EN
        w_wdog_cnt_nxt    = r_wdog_cnt;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                w_cpu_reset_nxt = 1'b1;
                if (start) begin
                    w_state_nxt      = S_PRE_RST;
                    w_load_count_nxt = '0;
                    w_err_nxt        = 1'b0;
                    w_done_nxt       = 1'b0;
                    w_busy_nxt       = 1'b1;
                    w_run_len_nxt    = run_cycles;
                end
            end
            S_PRE_RST: begin
                w_state_nxt       = S_LOAD;
                w_cpu_reset_nxt   = 1'b0;
                w_instr_ready_nxt = 1'b1;
                w_load_end_nxt    = 1'b0;
`ifdef SEQ_WATCHDOG_EN
                w_wdog_cnt_nxt    = '0;
`endif
            end
            S_LOAD: begin
                if (r_load_end) begin
                    w_state_nxt     = S_POST_RST;
                    w_cpu_reset_nxt = 1'b1;
                    w_load_end_nxt  = 1'b0;
                end else if (w_beat) begin
                    w_cpu_load_nxt   = 1'b1;
                    w_cpu_instr_nxt  = instr_data;
                    w_load_count_nxt = r_load_count + CNT_W'(1);
`ifdef SEQ_WATCHDOG_EN
                    w_wdog_cnt_nxt   = '0;
`endif
                    if (instr_last || w_last_slot) begin
                        w_load_end_nxt    = 1'b1;
                        w_instr_ready_nxt = 1'b0;
                        if (!instr_last) begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
`ifdef SEQ_WATCHDOG_EN
                else if (r_wdog_cnt == c_wdog_w'(WDOG_CYCLES - 1)) begin
                    w_state_nxt       = S_DONE;
                    w_err_nxt         = 1'b1;
                    w_instr_ready_nxt = 1'b0;
                    w_cpu_reset_nxt   = 1'b1;
                    w_busy_nxt        = 1'b0;
                    w_done_nxt        = 1'b1;
                end else begin
                    w_wdog_cnt_nxt = r_wdog_cnt + c_wdog_w'(1);
                end
`endif
            end
            S_POST_RST: begin
                w_state_nxt     = S_RUN;
                w_cpu_reset_nxt = 1'b0;
                w_run_cnt_nxt   = '0;
            end
            S_RUN: begin
                w_run_cnt_nxt = r_run_cnt + 16'd1;
                // Zero run length means free-run until halt_req.
                if (halt_req || ((r_run_len != 16'd0) && (r_run_cnt == r_run_len - 16'd1))) begin
                    w_state_nxt     = S_DONE;
                    w_cpu_reset_nxt = 1'b1;
                    w_busy_nxt      = 1'b0;
                    w_done_nxt      = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_cpu_reset_nxt = 1'b1;
                w_busy_nxt      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state       <= S_IDLE;
            r_load_end    <= 1'b0;
            r_run_len     <= '0;
            r_run_cnt     <= '0;
            r_instr_ready <= 1'b0;
            r_cpu_reset   <= 1'b1;
            r_cpu_load    <= 1'b0;
            r_cpu_instr   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_load_count  <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_load_end    <= w_load_end_nxt;
            r_run_len     <= w_run_len_nxt;
            r_run_cnt     <= w_run_cnt_nxt;
            r_instr_ready <= w_instr_ready_nxt;
            r_cpu_reset   <= w_cpu_reset_nxt;
            r_cpu_load    <= w_cpu_load_nxt;
            r_cpu_instr   <= w_cpu_instr_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_load_count  <= w_load_count_nxt;
            r_err         <= w_err_nxt;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_wdog_cnt <= '0;
        end else begin
            r_wdog_cnt <= w_wdog_cnt_nxt;
        end
    end
`endif

    assign instr_ready = r_instr_ready;
    assign cpu_reset   = r_cpu_reset;
    assign cpu_load    = r_cpu_load;
    assign cpu_instr   = r_cpu_instr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign load_count  = r_load_count;
    assign err         = r_err;

endmodule
`default_nettype wire
